// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    localparam int REG_AW_DEF  = 4;
    localparam int MUL_LAT_DEF = 4;
    localparam int STAT_W      = 16;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - load-use comparator: EX load destination vs ID source registers
module hazard_cmp #(
    parameter int REG_AW = hazard_pkg::REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_ifid_rs,
    input  logic [REG_AW-1:0] i_ifid_rt,
    input  logic              i_ifid_uses_rt,
    input  logic [REG_AW-1:0] i_idex_rt,
    input  logic              i_idex_memread,
    output logic              o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit   = (i_idex_rt == i_ifid_rs);
    assign w_rt_hit   = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
    assign o_load_use = i_idex_memread && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the five-stage core
// Optional statistics counters built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] IFID_RS,
    input  logic [REG_AW-1:0] IFID_RT,
    input  logic              IFID_USES_RT,
    input  logic [REG_AW-1:0] IDEX_RT,
    input  logic              IDEX_MemRead,
    input  logic              EX_Multi,
    input  logic              EX_BranchTaken,
    output logic              PC_WRITE,
    output logic              IFID_WRITE,
    output logic              IFID_FLUSH,
    output logic              IDEX_WRITE,
    output logic              IDEX_FLUSH,
    output logic              EXMEM_BUBBLE,
    output logic [STAT_W-1:0] STALL_CNT,
    output logic [STAT_W-1:0] FLUSH_CNT
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_load_use;

    hazard_cmp #(
        .REG_AW (REG_AW)
    ) u_cmp (
        .i_ifid_rs      (IFID_RS),
        .i_ifid_rt      (IFID_RT),
        .i_ifid_uses_rt (IFID_USES_RT),
        .i_idex_rt      (IDEX_RT),
        .i_idex_memread (IDEX_MemRead),
        .o_load_use     (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        PC_WRITE     = 1'b1;
        IFID_WRITE   = 1'b1;
        IFID_FLUSH   = 1'b0;
        IDEX_WRITE   = 1'b1;
        IDEX_FLUSH   = 1'b0;
        EXMEM_BUBBLE = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IFID_FLUSH = 1'b1;
                        IDEX_FLUSH = 1'b1;
                    end else if (EX_Multi) begin
                        PC_WRITE     = 1'b0;
                        IFID_WRITE   = 1'b0;
                        IDEX_WRITE   = 1'b0;
                        EXMEM_BUBBLE = 1'b1;
                        w_cnt_nxt    = CNT_INIT;
                        w_state_nxt  = MUL_WAIT;
                    end else if (w_load_use) begin
                        PC_WRITE   = 1'b0;
                        IFID_WRITE = 1'b0;
                        IDEX_FLUSH = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    // cnt==0 is the release cycle: defaults let the result leave EX
                    if (r_cnt != '0) begin
                        PC_WRITE     = 1'b0;
                        IFID_WRITE   = 1'b0;
                        IDEX_WRITE   = 1'b0;
                        EXMEM_BUBBLE = 1'b1;
                        w_cnt_nxt    = r_cnt - 1'b1;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!PC_WRITE && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (IFID_FLUSH && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FLUSH_CNT = r_flush_cnt;
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    // {PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_WRITE, IDEX_FLUSH, EXMEM_BUBBLE}
    localparam logic [5:0] C_DEF  = 6'b110100;
    localparam logic [5:0] C_LU   = 6'b000110;
    localparam logic [5:0] C_HOLD = 6'b000001;
    localparam logic [5:0] C_BR   = 6'b111110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ifid_rs, ifid_rt, idex_rt;
    logic        ifid_uses_rt, idex_memread, ex_multi, ex_branch;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble;
    logic [15:0] stall_cnt, flush_cnt;
    logic [5:0]  w_ctl;

    int n_tests = 0;
    int n_fail  = 0;

    assign w_ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(4), .MUL_LAT(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IFID_RS        (ifid_rs),
        .IFID_RT        (ifid_rt),
        .IFID_USES_RT   (ifid_uses_rt),
        .IDEX_RT        (idex_rt),
        .IDEX_MemRead   (idex_memread),
        .EX_Multi       (ex_multi),
        .EX_BranchTaken (ex_branch),
        .PC_WRITE       (pc_write),
        .IFID_WRITE     (ifid_write),
        .IFID_FLUSH     (ifid_flush),
        .IDEX_WRITE     (idex_write),
        .IDEX_FLUSH     (idex_flush),
        .EXMEM_BUBBLE   (exmem_bubble),
        .STALL_CNT      (stall_cnt),
        .FLUSH_CNT      (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are set at a falling edge; outputs are checked 1ns later, then one cycle elapses.
    task automatic tick(input string tag, input logic [5:0] exp);
        #1;
        check(tag, {26'd0, w_ctl}, {26'd0, exp});
        @(negedge clk);
    endtask

    task automatic idle();
        ifid_rs = 4'd1; ifid_rt = 4'd2; ifid_uses_rt = 1'b1;
        idex_rt = 4'd7; idex_memread = 1'b0; ex_multi = 1'b0; ex_branch = 1'b0;
    endtask

    logic [15:0] exp_stall, exp_flush;

    initial begin
        idle();
        rst_n = 1'b0;
        ex_multi = 1'b1;
        @(negedge clk);
        tick("rst_cyc1", C_DEF);
        tick("rst_cyc2", C_DEF);
        rst_n = 1'b1;
        ex_multi = 1'b0;
        tick("post_rst", C_DEF);
        check("stall_after_rst", {16'd0, stall_cnt}, 32'd0);
        check("flush_after_rst", {16'd0, flush_cnt}, 32'd0);

        // load-use on RS
        idex_memread = 1'b1; idex_rt = 4'd4; ifid_rs = 4'd4;
        tick("lu_rs", C_LU);
        idex_memread = 1'b0;
        tick("lu_rs_next", C_DEF);
        // RT match but not used: no stall
        idex_memread = 1'b1; idex_rt = 4'd4; ifid_rs = 4'd9; ifid_rt = 4'd4; ifid_uses_rt = 1'b0;
        tick("lu_rt_unused", C_DEF);
        // RT match and used: stall
        ifid_uses_rt = 1'b1;
        tick("lu_rt_used", C_LU);
        idle();

        // multi-cycle op, MUL_LAT=4: three frozen cycles then release
        ex_multi = 1'b1;
        tick("mul_c1", C_HOLD);
        ex_multi = 1'b0;
        tick("mul_c2", C_HOLD);
        tick("mul_c3", C_HOLD);
        tick("mul_release", C_DEF);
        tick("mul_after", C_DEF);

        // branch dominates multi and load-use
        ex_branch = 1'b1; ex_multi = 1'b1;
        idex_memread = 1'b1; idex_rt = 4'd1; ifid_rs = 4'd1;
        tick("br_prio", C_BR);
        idle();
        tick("br_no_mulwait", C_DEF);
        ex_branch = 1'b1;
        tick("br2", C_BR);
        idle();
        #1;
`ifdef HAZARD_STATS_EN
        exp_stall = 16'd5; exp_flush = 16'd2;
`else
        exp_stall = 16'd0; exp_flush = 16'd0;
`endif
        check("stall_cnt_mix", {16'd0, stall_cnt}, {16'd0, exp_stall});
        check("flush_cnt_mix", {16'd0, flush_cnt}, {16'd0, exp_flush});
        tick("idle_mix", C_DEF);

        // reset on the second MUL_WAIT cycle
        ex_multi = 1'b1;
        tick("mr_c1", C_HOLD);
        ex_multi = 1'b0;
        tick("mr_c2", C_HOLD);
        rst_n = 1'b0;
        tick("mr_in_rst", C_DEF);
        rst_n = 1'b1;
        tick("mr_after_rst", C_DEF);
        // fresh multi with a branch arriving mid-wait (must be ignored)
        ex_multi = 1'b1;
        tick("mr2_c1", C_HOLD);
        ex_multi = 1'b0; ex_branch = 1'b1;
        tick("mr2_c2_br_ign", C_HOLD);
        ex_branch = 1'b0;
        tick("mr2_c3", C_HOLD);
        tick("mr2_release", C_DEF);
        #1;
`ifdef HAZARD_STATS_EN
        exp_stall = 16'd3; exp_flush = 16'd0;
`else
        exp_stall = 16'd0; exp_flush = 16'd0;
`endif
        check("stall_cnt_rst", {16'd0, stall_cnt}, {16'd0, exp_stall});
        check("flush_cnt_rst", {16'd0, flush_cnt}, {16'd0, exp_flush});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
